// File: rtl/cci_mpf_rd_arb_pkg.sv
// cci_mpf_rd_arb_pkg: shared client types and Mdata tag helpers for the MPF read arbiter
package cci_mpf_rd_arb_pkg;
  localparam int MAX_CLIENTS = 16;
  localparam int MAX_ID_BITS = 4;
  localparam int MAX_MDATA_BITS = 64;
  typedef logic [MAX_ID_BITS-1:0] t_client_idx;
  typedef logic [MAX_CLIENTS-1:0] t_client_mask;
  typedef logic [MAX_MDATA_BITS-1:0] t_mdata;
  function automatic int id_bits(input int n_clients);
    return (n_clients <= 2) ? 1 : $clog2(n_clients);
  endfunction
  function automatic t_mdata tag_insert(input t_mdata md, input int n_md, input int n_id, input t_client_idx idx);
    t_mdata r = md;
    for (int i = 0; i < MAX_ID_BITS; i++)
      if (i < n_id) r[n_md - n_id + i] = idx[i];
    return r;
  endfunction
  function automatic t_mdata tag_strip(input t_mdata md, input int n_md, input int n_id);
    return tag_insert(md, n_md, n_id, '0);
  endfunction
  function automatic t_client_idx tag_get(input t_mdata md, input int n_md, input int n_id);
    t_client_idx r = '0;
    for (int i = 0; i < MAX_ID_BITS; i++)
      if (i < n_id) r[i] = md[n_md - n_id + i];
    return r;
  endfunction
endpackage

// File: rtl/cci_mpf_prim_rr_arb.sv
// cci_mpf_prim_rr_arb: round-robin arbiter with one-hot grant, index and rotating pointer
module cci_mpf_prim_rr_arb
  import cci_mpf_rd_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CLIENTS-1:0] req,
  output logic [N_CLIENTS-1:0] grant,
  output t_client_idx          grant_idx,
  output logic                 grant_valid
);
  t_client_idx ptr_q, ptr_d;
  // First requester at or after the pointer wins, then wrap to the low indices
  always_comb begin
    grant_valid = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N_CLIENTS; i++)
      if (!grant_valid && req[i] && i >= int'(ptr_q)) begin
        grant_valid = 1'b1;
        grant_idx = t_client_idx'(i);
      end
    for (int i = 0; i < N_CLIENTS; i++)
      if (!grant_valid && req[i]) begin
        grant_valid = 1'b1;
        grant_idx = t_client_idx'(i);
      end
    grant = N_CLIENTS'(grant_valid) << grant_idx;
    ptr_d = !grant_valid ? ptr_q : (int'(grant_idx) == N_CLIENTS - 1) ? '0 : grant_idx + 1'b1;
  end
  // Pointer moves just past the winner; idle cycles leave it alone
  always_ff @(posedge clk) begin
    ptr_q <= reset ? '0 : ptr_d;
  end
endmodule

// File: rtl/cci_mpf_shim_rd_arbiter.sv
// cci_mpf_shim_rd_arbiter: shares one c0Tx read channel among clients, tags Mdata and steers responses
module cci_mpf_shim_rd_arbiter
  import cci_mpf_rd_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int N_ADDR_BITS = 42,
  parameter int N_MDATA_BITS = 16,
  parameter int N_DATA_BITS = 512,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_CLIENTS-1:0]              cli_req_valid,
  input  logic [N_CLIENTS*N_ADDR_BITS-1:0]  cli_req_addr,
  input  logic [N_CLIENTS*N_MDATA_BITS-1:0] cli_req_mdata,
  output logic [N_CLIENTS-1:0]              cli_req_grant,
  output logic [N_CLIENTS-1:0]              cli_rsp_valid,
  output logic [N_MDATA_BITS-1:0]           cli_rsp_mdata,
  output logic [N_DATA_BITS-1:0]            cli_rsp_data,
  output logic                              fiu_req_valid,
  output logic [N_ADDR_BITS-1:0]            fiu_req_addr,
  output logic [N_MDATA_BITS-1:0]           fiu_req_mdata,
  input  logic                              fiu_alm_full,
  input  logic                              fiu_rsp_valid,
  input  logic [N_MDATA_BITS-1:0]           fiu_rsp_mdata,
  input  logic [N_DATA_BITS-1:0]            fiu_rsp_data,
  output logic                              err_unexp_rsp
);
  localparam int ID_BITS = id_bits(N_CLIENTS);
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
  logic                    alm_full_q;
  logic [N_CLIENTS-1:0]    elig, grant;
  t_client_idx             grant_idx, rsp_tag;
  logic                    grant_valid;
  logic [N_ADDR_BITS-1:0]  sel_addr;
  logic [N_MDATA_BITS-1:0] sel_mdata;
  logic                    fiu_req_valid_q, fiu_req_valid_d;
  logic [N_ADDR_BITS-1:0]  fiu_req_addr_q, fiu_req_addr_d;
  logic [N_MDATA_BITS-1:0] fiu_req_mdata_q, fiu_req_mdata_d;
  logic [N_CLIENTS-1:0]    cli_rsp_valid_q, cli_rsp_valid_d;
  logic [N_MDATA_BITS-1:0] cli_rsp_mdata_q, cli_rsp_mdata_d;
  logic [N_DATA_BITS-1:0]  cli_rsp_data_q;
  logic                    err_q, err_d;
  logic [CNT_BITS-1:0]     cnt_q [N_CLIENTS];
  logic [CNT_BITS-1:0]     cnt_d [N_CLIENTS];
  // A client competes only while under its cap and the registered almost-full is clear
  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++)
      elig[i] = cli_req_valid[i] && cnt_q[i] < CNT_BITS'(MAX_OUTSTANDING) && !alm_full_q;
  end
  cci_mpf_prim_rr_arb #(.N_CLIENTS(N_CLIENTS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (elig),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );
  // Mux the winner's request and stamp its index into the Mdata tag field
  always_comb begin
    sel_addr = '0;
    sel_mdata = '0;
    for (int i = 0; i < N_CLIENTS; i++)
      if (grant[i]) begin
        sel_addr = cli_req_addr[i*N_ADDR_BITS +: N_ADDR_BITS];
        sel_mdata = cli_req_mdata[i*N_MDATA_BITS +: N_MDATA_BITS];
      end
    fiu_req_valid_d = grant_valid;
    fiu_req_addr_d = sel_addr;
    fiu_req_mdata_d = N_MDATA_BITS'(tag_insert(t_mdata'(sel_mdata), N_MDATA_BITS, ID_BITS, grant_idx));
  end
  // Steer responses by tag and keep per-client in-flight counts; stray responses latch the error
  always_comb begin
    rsp_tag = tag_get(t_mdata'(fiu_rsp_mdata), N_MDATA_BITS, ID_BITS);
    cli_rsp_mdata_d = N_MDATA_BITS'(tag_strip(t_mdata'(fiu_rsp_mdata), N_MDATA_BITS, ID_BITS));
    err_d = err_q || (fiu_rsp_valid && int'(rsp_tag) >= N_CLIENTS);
    for (int i = 0; i < N_CLIENTS; i++) begin
      cli_rsp_valid_d[i] = fiu_rsp_valid && int'(rsp_tag) == i;
      err_d = err_d || (cli_rsp_valid_d[i] && cnt_q[i] == '0);
      cnt_d[i] = (grant[i] && !(cli_rsp_valid_d[i] && cnt_q[i] != '0)) ? cnt_q[i] + 1'b1 :
                 (!grant[i] && cli_rsp_valid_d[i] && cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : cnt_q[i];
    end
  end
  // All channel outputs and bookkeeping are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      alm_full_q <= 1'b0;
      fiu_req_valid_q <= 1'b0;
      fiu_req_addr_q <= '0;
      fiu_req_mdata_q <= '0;
      cli_rsp_valid_q <= '0;
      cli_rsp_mdata_q <= '0;
      cli_rsp_data_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) cnt_q[i] <= '0;
    end else begin
      alm_full_q <= fiu_alm_full;
      fiu_req_valid_q <= fiu_req_valid_d;
      fiu_req_addr_q <= fiu_req_addr_d;
      fiu_req_mdata_q <= fiu_req_mdata_d;
      cli_rsp_valid_q <= cli_rsp_valid_d;
      cli_rsp_mdata_q <= cli_rsp_mdata_d;
      cli_rsp_data_q <= fiu_rsp_data;
      err_q <= err_d;
      for (int i = 0; i < N_CLIENTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign cli_req_grant = grant;
  assign fiu_req_valid = fiu_req_valid_q;
  assign fiu_req_addr = fiu_req_addr_q;
  assign fiu_req_mdata = fiu_req_mdata_q;
  assign cli_rsp_valid = cli_rsp_valid_q;
  assign cli_rsp_mdata = cli_rsp_mdata_q;
  assign cli_rsp_data = cli_rsp_data_q;
  assign err_unexp_rsp = err_q;
  // Clients must leave the tag field clear; the arbiter overwrites it regardless
  assert property (@(posedge clk) disable iff (reset) grant_valid |-> sel_mdata[N_MDATA_BITS-1 -: ID_BITS] == '0);
endmodule

// File: tb/tb_cci_mpf_shim_rd_arbiter.sv
// tb_cci_mpf_shim_rd_arbiter: table-driven arbitration checks with scoreboarded request/response paths
module tb_cci_mpf_shim_rd_arbiter;
  localparam int N = 4;
  localparam int AW = 42;
  localparam int MW = 16;
  localparam int DW = 512;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] cli_req_valid, cli_req_grant, cli_rsp_valid;
  logic [N*AW-1:0] cli_req_addr;
  logic [N*MW-1:0] cli_req_mdata;
  logic [MW-1:0] cli_rsp_mdata, fiu_req_mdata, fiu_rsp_mdata;
  logic [DW-1:0] cli_rsp_data, fiu_rsp_data;
  logic [AW-1:0] fiu_req_addr;
  logic fiu_req_valid, fiu_alm_full, fiu_rsp_valid, err_unexp_rsp;
  always #5 clk = ~clk;
  cci_mpf_shim_rd_arbiter #(
    .N_CLIENTS(N), .N_ADDR_BITS(AW), .N_MDATA_BITS(MW), .N_DATA_BITS(DW), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cli_req_valid(cli_req_valid), .cli_req_addr(cli_req_addr), .cli_req_mdata(cli_req_mdata),
    .cli_req_grant(cli_req_grant), .cli_rsp_valid(cli_rsp_valid), .cli_rsp_mdata(cli_rsp_mdata),
    .cli_rsp_data(cli_rsp_data), .fiu_req_valid(fiu_req_valid), .fiu_req_addr(fiu_req_addr),
    .fiu_req_mdata(fiu_req_mdata), .fiu_alm_full(fiu_alm_full), .fiu_rsp_valid(fiu_rsp_valid),
    .fiu_rsp_mdata(fiu_rsp_mdata), .fiu_rsp_data(fiu_rsp_data), .err_unexp_rsp(err_unexp_rsp)
  );
  typedef struct {
    bit rst; logic [3:0] v; bit alm; bit rv; logic [15:0] rmd;
    logic [3:0] gnt; logic [3:0] erv; logic [15:0] ermd; bit err;
  } vec_t;
  typedef struct {logic [AW-1:0] addr; logic [MW-1:0] mdata;} req_t;
  typedef struct {logic [3:0] v; logic [MW-1:0] mdata; logic [DW-1:0] data;} rsp_t;
  vec_t tbl[$];
  req_t req_q[$];
  rsp_t rsp_q[$];
  logic [AW-1:0] caddr [N];
  logic [MW-1:0] cmd [N];
  int n_checks = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input bit rst, input logic [3:0] v, input bit alm, input bit rv, input logic [15:0] rmd,
                     input logic [3:0] gnt, input logic [3:0] erv, input logic [15:0] ermd, input bit err);
    tbl.push_back('{rst, v, alm, rv, rmd, gnt, erv, ermd, err});
  endtask
  task automatic g(input logic [3:0] v, input logic [3:0] gnt, input bit err);
    add(1'b0, v, 1'b0, 1'b0, 16'h0, gnt, 4'h0, 16'h0, err);
  endtask
  task automatic rst_entry();
    add(1'b1, 4'h0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 16'h0, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cli_req_valid = '0;
    fiu_alm_full = 1'b0;
    fiu_rsp_valid = 1'b0;
    fiu_rsp_mdata = '0;
    fiu_rsp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst grant", DW'(cli_req_grant), DW'(0));
    chk("rst fiu_req_valid", DW'(fiu_req_valid), DW'(0));
    chk("rst fiu_req_addr", DW'(fiu_req_addr), DW'(0));
    chk("rst fiu_req_mdata", DW'(fiu_req_mdata), DW'(0));
    chk("rst cli_rsp_valid", DW'(cli_rsp_valid), DW'(0));
    chk("rst cli_rsp_mdata", DW'(cli_rsp_mdata), DW'(0));
    chk("rst cli_rsp_data", cli_rsp_data, DW'(0));
    chk("rst err", DW'(err_unexp_rsp), DW'(0));
    req_q.delete();
    rsp_q.delete();
  endtask
  task automatic step(input vec_t t, input int s);
    logic [DW-1:0] d;
    req_t r;
    rsp_t e;
    @(negedge clk);
    d = {16{32'hA5A50000 | 32'(s)}};
    cli_req_valid = t.v;
    fiu_alm_full = t.alm;
    fiu_rsp_valid = t.rv;
    fiu_rsp_mdata = t.rmd;
    fiu_rsp_data = d;
    #1;
    chk($sformatf("grant s%0d", s), DW'(cli_req_grant), DW'(t.gnt));
    chk($sformatf("fiu_req_valid s%0d", s), DW'(fiu_req_valid), DW'(req_q.size() != 0));
    if (req_q.size() != 0) begin
      r = req_q.pop_front();
      if (fiu_req_valid) begin
        chk($sformatf("fiu_req_addr s%0d", s), DW'(fiu_req_addr), DW'(r.addr));
        chk($sformatf("fiu_req_mdata s%0d", s), DW'(fiu_req_mdata), DW'(r.mdata));
      end
    end
    e = '{4'h0, '0, '0};
    if (rsp_q.size() != 0) e = rsp_q.pop_front();
    chk($sformatf("cli_rsp_valid s%0d", s), DW'(cli_rsp_valid), DW'(e.v));
    if (e.v != 4'h0) begin
      chk($sformatf("cli_rsp_mdata s%0d", s), DW'(cli_rsp_mdata), DW'(e.mdata));
      chk($sformatf("cli_rsp_data s%0d", s), cli_rsp_data, e.data);
    end
    chk($sformatf("err s%0d", s), DW'(err_unexp_rsp), DW'(t.err));
    for (int i = 0; i < N; i++)
      if (t.gnt[i]) req_q.push_back('{caddr[i], {2'(i), cmd[i][13:0]}});
    if (t.rv) rsp_q.push_back('{t.erv, t.ermd, d});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    cli_req_valid = '0;
    fiu_alm_full = 1'b0;
    fiu_rsp_valid = 1'b0;
    fiu_rsp_mdata = '0;
    fiu_rsp_data = '0;
    for (int i = 0; i < N; i++) begin
      caddr[i] = AW'(42'h2_0000_1000) + AW'(i * 'h40);
      cmd[i] = 16'h0A00 + 16'(i * 3);
      cli_req_addr[i*AW +: AW] = caddr[i];
      cli_req_mdata[i*MW +: MW] = cmd[i];
    end
    rst_entry();
    g(4'hF, 4'h1, 1'b0); g(4'hF, 4'h2, 1'b0); g(4'hF, 4'h4, 1'b0); g(4'hF, 4'h8, 1'b0);
    g(4'hF, 4'h1, 1'b0); g(4'h0, 4'h0, 1'b0);
    rst_entry();
    g(4'hA, 4'h2, 1'b0); g(4'hA, 4'h8, 1'b0); g(4'hA, 4'h2, 1'b0); g(4'hA, 4'h8, 1'b0);
    g(4'hB, 4'h1, 1'b0); g(4'hB, 4'h2, 1'b0); g(4'hB, 4'h8, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b1, 16'hC005, 4'h0, 4'h8, 16'h0005, 1'b0);
    g(4'h0, 4'h0, 1'b0);
    add(1'b0, 4'hF, 1'b1, 1'b0, 16'h0, 4'h1, 4'h0, 16'h0, 1'b0);
    add(1'b0, 4'hF, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 16'h0, 1'b0);
    g(4'hF, 4'h0, 1'b0); g(4'hF, 4'h2, 1'b0); g(4'hF, 4'h4, 1'b0); g(4'hF, 4'h8, 1'b0);
    g(4'hF, 4'h1, 1'b0); g(4'hF, 4'h4, 1'b0); g(4'hF, 4'h8, 1'b0); g(4'hF, 4'h1, 1'b0);
    g(4'hF, 4'h4, 1'b0); g(4'hF, 4'h4, 1'b0); g(4'hF, 4'h0, 1'b0);
    add(1'b0, 4'hF, 1'b0, 1'b1, 16'h4077, 4'h0, 4'h2, 16'h0077, 1'b0);
    g(4'hF, 4'h2, 1'b0); g(4'hF, 4'h0, 1'b0);
    rst_entry();
    g(4'h4, 4'h4, 1'b0); g(4'h4, 4'h4, 1'b0); g(4'h4, 4'h4, 1'b0); g(4'h4, 4'h4, 1'b0);
    g(4'h4, 4'h0, 1'b0); g(4'h4, 4'h0, 1'b0);
    add(1'b0, 4'h4, 1'b0, 1'b1, 16'h8001, 4'h0, 4'h4, 16'h0001, 1'b0);
    add(1'b0, 4'h4, 1'b0, 1'b1, 16'h8002, 4'h4, 4'h4, 16'h0002, 1'b0);
    g(4'h4, 4'h4, 1'b0); g(4'h4, 4'h0, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b1, 16'h0009, 4'h0, 4'h1, 16'h0009, 1'b0);
    g(4'h0, 4'h0, 1'b1); g(4'h0, 4'h0, 1'b1);
    for (int s = 0; s < tbl.size(); s++) begin
      if (tbl[s].rst) do_reset();
      else step(tbl[s], s);
    end
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
